ov_pixel_capture: RTL and testbench

Capture front end for an OV7670-class sensor running YUV422 output, clocked by the sensor pixel clock. It assembles byte pairs into 16-bit pixel words and flags line/frame boundaries from vsync/href. It also pairs consecutive words into one YUYV group and converts that group to a 9-bit RGB333 sample. Downstream frame-buffer logic writes the RGB samples into memory and uses `frame_done` to restart its address counters.

---
 rtl/ov_cap_pkg.sv | 25 ++
 rtl/ov_yuv_rgb333.sv | 71 +++++++
 rtl/ov_pixel_capture.sv | 126 ++++++++++++
 tb/tb_ov_pixel_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ov_cap_pkg.sv
// ov_cap_pkg
// Shared definitions for the OV7670-class pixel capture front end: capture FSM
// states, YUV->RGB conversion coefficients (Q8 fixed point), the chroma offset
// and the bit positions of the RGB333 fields.
package ov_cap_pkg;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } cap_state_t;

    // Q8 coefficients: 1.402, 0.344, 0.714, 1.772 scaled by 256.
    localparam logic signed [19:0] COEF_RV = 20'sd359;
    localparam logic signed [19:0] COEF_GU = 20'sd88;
    localparam logic signed [19:0] COEF_GV = 20'sd183;
    localparam logic signed [19:0] COEF_BU = 20'sd454;

    localparam logic signed [19:0] UV_OFFSET = 20'sd128;

    // LSB position of each 3-bit channel inside the 9-bit RGB333 word.
    localparam int RGB_R_LSB = 6;
    localparam int RGB_G_LSB = 3;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/ov_yuv_rgb333.sv
// ov_yuv_rgb333
// Purely combinational conversion of one YUYV group to an RGB333 sample.
// Only Y0 is used for luma; Y1 shares the chroma but is not converted.
//
// Ports:
//   yuv  in  32  {Y0, U, Y1, V}
//   rgb  out  9  {R[2:0], G[2:0], B[2:0]}
//
// Build option: define OVCAP_GRAY_EN to replace the colour matrix with a
// grayscale output {Y0[7:5], Y0[7:5], Y0[7:5]} (no multipliers, U/V ignored).
module ov_yuv_rgb333
    import ov_cap_pkg::*;
(
    input  logic [31:0] yuv,
    output logic [8:0]  rgb
);

    logic [7:0] unused_y1;
    assign unused_y1 = yuv[15:8];

`ifdef OVCAP_GRAY_EN

    logic [15:0] unused_uv;
    assign unused_uv = {yuv[23:16], yuv[7:0]};

    always_comb begin
        rgb = '0;
        rgb[RGB_R_LSB +: 3] = yuv[31:29];
        rgb[RGB_G_LSB +: 3] = yuv[31:29];
        rgb[RGB_B_LSB +: 3] = yuv[31:29];
    end

`else

    // Clamp a floored channel value to 0..255 and keep its top three bits.
    function automatic logic [2:0] sat_msb3(input logic signed [19:0] x);
        logic [7:0] c;
        if (x < 20'sd0)
            c = 8'd0;
        else if (x > 20'sd255)
            c = 8'hFF;
        else
            c = x[7:0];
        return c[7:5];
    endfunction

    logic signed [19:0] y0_s;
    logic signed [19:0] u_s;
    logic signed [19:0] v_s;
    logic signed [19:0] r_val;
    logic signed [19:0] g_val;
    logic signed [19:0] b_val;

    // Worst-case sums stay within +/-2^17, so 20 bits never overflow; the
    // arithmetic right shift floors negative sums toward -inf.
    always_comb begin
        y0_s  = $signed({12'd0, yuv[31:24]});
        u_s   = $signed({12'd0, yuv[23:16]}) - UV_OFFSET;
        v_s   = $signed({12'd0, yuv[7:0]})   - UV_OFFSET;
        r_val = ((y0_s <<< 8) + COEF_RV * v_s) >>> 8;
        g_val = ((y0_s <<< 8) - COEF_GU * u_s - COEF_GV * v_s) >>> 8;
        b_val = ((y0_s <<< 8) + COEF_BU * u_s) >>> 8;
        rgb = '0;
        rgb[RGB_R_LSB +: 3] = sat_msb3(r_val);
        rgb[RGB_G_LSB +: 3] = sat_msb3(g_val);
        rgb[RGB_B_LSB +: 3] = sat_msb3(b_val);
    end

`endif

endmodule

// File: rtl/ov_pixel_capture.sv
// ov_pixel_capture
// Capture front end for an OV7670-class sensor in YUV422 mode, running on the
// sensor pixel clock. Assembles byte pairs into 16-bit words, pairs words into
// YUYV groups converted to RGB333, and flags the end of each frame.
//
// Ports:
//   p_clock      in   1   sensor pixel clock
//   rst          in   1   synchronous active-high reset
//   vsync        in   1   high during vertical blanking
//   href         in   1   high while line bytes are valid
//   p_data       in   8   sensor data byte
//   pixel_data   out 16   assembled word {first byte, second byte}
//   pixel_valid  out  1   one-cycle strobe, pixel_data valid
//   frame_done   out  1   one-cycle strobe after vsync rises during capture
//   rgb          out  9   {R,G,B} RGB333, combinational from the word pair
//   rgb_valid    out  1   rgb valid, on every second word of a line
//
// Build option: OVCAP_GRAY_EN (see ov_yuv_rgb333) selects grayscale output.
module ov_pixel_capture
    import ov_cap_pkg::*;
(
    input  logic        p_clock,
    input  logic        rst,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  p_data,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [8:0]  rgb,
    output logic        rgb_valid
);

    cap_state_t  state;
    cap_state_t  state_d;
    logic        vsync_q;
    logic        byte_phase;
    logic        byte_phase_d;
    logic        pair_phase;
    logic        pair_phase_d;
    logic        pixel_valid_d;
    logic        rgb_valid_d;
    logic        frame_done_d;
    logic        load_hi;
    logic        load_lo;
    logic [15:0] prev_word;

    always_comb begin
        state_d       = state;
        byte_phase_d  = byte_phase;
        pair_phase_d  = pair_phase;
        pixel_valid_d = 1'b0;
        rgb_valid_d   = 1'b0;
        frame_done_d  = 1'b0;
        load_hi       = 1'b0;
        load_lo       = 1'b0;
        case (state)
            WAIT_FRAME: begin
                byte_phase_d = 1'b0;
                pair_phase_d = 1'b0;
                if (vsync_q && !vsync)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (vsync) begin
                    // Blanking starts: end the frame and drop any partial line.
                    state_d      = WAIT_FRAME;
                    frame_done_d = 1'b1;
                    byte_phase_d = 1'b0;
                    pair_phase_d = 1'b0;
                end else if (href) begin
                    byte_phase_d = ~byte_phase;
                    if (!byte_phase) begin
                        load_hi = 1'b1;
                    end else begin
                        load_lo       = 1'b1;
                        pixel_valid_d = 1'b1;
                        rgb_valid_d   = pair_phase;
                        pair_phase_d  = ~pair_phase;
                    end
                end else begin
                    byte_phase_d = 1'b0;
                    pair_phase_d = 1'b0;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge p_clock) begin
        if (rst) begin
            state       <= WAIT_FRAME;
            vsync_q     <= 1'b0;
            byte_phase  <= 1'b0;
            pair_phase  <= 1'b0;
            pixel_valid <= 1'b0;
            rgb_valid   <= 1'b0;
            frame_done  <= 1'b0;
            pixel_data  <= '0;
            prev_word   <= '0;
        end else begin
            state       <= state_d;
            vsync_q     <= vsync;
            byte_phase  <= byte_phase_d;
            pair_phase  <= pair_phase_d;
            pixel_valid <= pixel_valid_d;
            rgb_valid   <= rgb_valid_d;
            frame_done  <= frame_done_d;
            if (load_hi)
                pixel_data[15:8] <= p_data;
            if (load_lo) begin
                pixel_data[7:0] <= p_data;
                // First word of a pair is kept so the second word can be
                // converted together with it.
                if (!pair_phase)
                    prev_word <= {pixel_data[15:8], p_data};
            end
        end
    end

    ov_yuv_rgb333 u_yuv_rgb333 (
        .yuv (({prev_word, pixel_data})),
        .rgb (rgb)
    );

endmodule

// File: tb/tb_ov_pixel_capture.sv
module tb_ov_pixel_capture;

    logic        p_clock = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic [7:0]  p_data;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic [8:0]  rgb;
    logic        rgb_valid;

    int n_checks = 0;
    int n_errors = 0;

    int          pv_cnt;
    int          rv_cnt;
    int          fd_cnt;
    logic [8:0]  last_rgb;
    logic [15:0] last_pix;
    logic [7:0]  line_buf [0:7];

    always #5 p_clock = ~p_clock;

    ov_pixel_capture dut (
        .p_clock     (p_clock),
        .rst         (rst),
        .vsync       (vsync),
        .href        (href),
        .p_data      (p_data),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        pv_cnt   = 0;
        rv_cnt   = 0;
        fd_cnt   = 0;
        last_rgb = '0;
        last_pix = '0;
    endtask

    // Drive one cycle of inputs, then observe outputs 1 ns after the edge.
    task automatic cycle(input logic v, input logic h, input logic [7:0] d);
        vsync  = v;
        href   = h;
        p_data = d;
        @(posedge p_clock);
        #1;
        if (pixel_valid) begin
            pv_cnt++;
            last_pix = pixel_data;
        end
        if (rgb_valid) begin
            rv_cnt++;
            last_rgb = rgb;
        end
        if (frame_done)
            fd_cnt++;
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b1, line_buf[i]);
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_start();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_line(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [8:0] exp_rgb);
        line_buf[0] = b0;
        line_buf[1] = b1;
        line_buf[2] = b2;
        line_buf[3] = b3;
        clear_counts();
        send_line(4);
        check({tag, "_pv"}, pv_cnt, 2);
        check({tag, "_rv"}, rv_cnt, 1);
        check({tag, "_rgb"}, {23'd0, last_rgb}, {23'd0, exp_rgb});
        check({tag, "_pix"}, {16'd0, last_pix}, {16'd0, b2, b3});
    endtask

    initial begin
        rst    = 1'b1;
        vsync  = 1'b0;
        href   = 1'b0;
        p_data = 8'h00;
        clear_counts();
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("rst_pixel_valid", {31'd0, pixel_valid}, 0);
        check("rst_rgb_valid", {31'd0, rgb_valid}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_pixel_data", {16'd0, pixel_data}, 0);
        rst = 1'b0;

        // Bytes before any vsync fall are ignored.
        line_buf[0] = 8'h12; line_buf[1] = 8'h34; line_buf[2] = 8'h56; line_buf[3] = 8'h78;
        clear_counts();
        send_line(4);
        check("preframe_pv", pv_cnt, 0);

        frame_start();
        clear_counts();
        cycle(1'b0, 1'b1, 8'h12);
        check("first_byte_pv", {31'd0, pixel_valid}, 0);
        cycle(1'b0, 1'b1, 8'h34);
        check("word_pv", {31'd0, pixel_valid}, 1);
        check("word_data", {16'd0, pixel_data}, 32'h1234);
        check("word_rv", {31'd0, rgb_valid}, 0);
        cycle(1'b0, 1'b0, 8'h00);
        check("word_pv_drop", {31'd0, pixel_valid}, 0);

        run_line("mid_gray", 8'h80, 8'h80, 8'h80, 8'h80, 9'b100_100_100);
        run_line("white",    8'hFF, 8'h80, 8'hFF, 8'h80, 9'h1FF);
        run_line("black",    8'h00, 8'h80, 8'h00, 8'h80, 9'h000);
`ifdef OVCAP_GRAY_EN
        run_line("red_clamp", 8'h4C, 8'h55, 8'h4C, 8'hFF, 9'h092);
        run_line("gray_a0",   8'hA0, 8'h00, 8'h11, 8'hFF, 9'b101_101_101);
`else
        run_line("red_clamp", 8'h4C, 8'h55, 8'h4C, 8'hFF, 9'h1C0);
        run_line("color_a0",  8'hA0, 8'h00, 8'h11, 8'hFF, 9'h1D8);
`endif

        // Three words: the odd word is left unpaired at href low.
        line_buf[0] = 8'h11; line_buf[1] = 8'h22; line_buf[2] = 8'h33;
        line_buf[3] = 8'h44; line_buf[4] = 8'h55; line_buf[5] = 8'h66;
        clear_counts();
        send_line(6);
        check("odd_pv", pv_cnt, 3);
        check("odd_rv", rv_cnt, 1);
        check("odd_last_pix", {16'd0, last_pix}, 32'h5566);
        line_buf[0] = 8'h80; line_buf[1] = 8'h80;
        clear_counts();
        send_line(2);
        check("no_cross_line_pair_pv", pv_cnt, 1);
        check("no_cross_line_pair_rv", rv_cnt, 0);
        run_line("after_odd", 8'h80, 8'h80, 8'h80, 8'h80, 9'b100_100_100);

        // vsync rising mid-line: abort partial word, one frame_done pulse.
        clear_counts();
        cycle(1'b0, 1'b1, 8'hAA);
        cycle(1'b1, 1'b1, 8'hBB);
        check("abort_fd", {31'd0, frame_done}, 1);
        check("abort_pv", {31'd0, pixel_valid}, 0);
        cycle(1'b1, 1'b1, 8'hCC);
        check("fd_one_cycle", {31'd0, frame_done}, 0);
        cycle(1'b1, 1'b0, 8'h00);
        check("fd_count", fd_cnt, 1);
        check("abort_pv_count", pv_cnt, 0);
        cycle(1'b0, 1'b0, 8'h00);
        clear_counts();
        cycle(1'b0, 1'b1, 8'hCC);
        cycle(1'b0, 1'b1, 8'hDD);
        check("post_abort_pv", {31'd0, pixel_valid}, 1);
        check("post_abort_data", {16'd0, pixel_data}, 32'hCCDD);
        cycle(1'b0, 1'b0, 8'h00);

        // Reset mid-line drops state; capture waits for next vsync fall.
        cycle(1'b0, 1'b1, 8'hEE);
        rst = 1'b1;
        cycle(1'b0, 1'b1, 8'hFF);
        check("midrst_pv", {31'd0, pixel_valid}, 0);
        check("midrst_data", {16'd0, pixel_data}, 0);
        rst = 1'b0;
        line_buf[0] = 8'h01; line_buf[1] = 8'h02; line_buf[2] = 8'h03; line_buf[3] = 8'h04;
        clear_counts();
        send_line(4);
        check("midrst_wait_pv", pv_cnt, 0);
        frame_start();
        run_line("after_rst", 8'h80, 8'h80, 8'h80, 8'h80, 9'b100_100_100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
